// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch levels in, debounced levels, edge pulses and LED out
interface switch_debouncer_if #(parameter int WIDTH = 2);
  logic [WIDTH-1:0] switch_in;
  logic [WIDTH-1:0] switch_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             led;
  modport master (output switch_in, input switch_db, rise, fall, led);
  modport slave (input switch_in, output switch_db, rise, fall, led);
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel sync, stability-count debounce, edge pulses and AND-reduced LED
module switch_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int WIDTH = 2
) (
  input logic clk,
  input logic rst,
  switch_debouncer_if.slave sw
);
  localparam int cnt_w = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] db, rise, fall;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic s1, s2, d, r, f;
    logic [cnt_w-1:0] cnt;
    // synchronise, then accept a new level only after it has held for STABLE_CYCLES cycles
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        d <= 1'b0;
        r <= 1'b0;
        f <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= sw.switch_in[i];
        s2 <= s1;
        r <= 1'b0;
        f <= 1'b0;
        if (s2 == d) cnt <= '0;
        else if (cnt == cnt_max) begin
          d <= s2;
          cnt <= '0;
          r <= s2;
          f <= ~s2;
        end else cnt <= cnt + 1'b1;
      end
    assign db[i] = d;
    assign rise[i] = r;
    assign fall[i] = f;
  end
  assign sw.switch_db = db;
  assign sw.rise = rise;
  assign sw.fall = fall;
  assign sw.led = &db;
endmodule
